// File: rtl/mainfsm_pkg.sv
// Shared types for the multicycle ARM main controller: state encodings, mux selects, control vector.
// Fixed state encodings so external observers and debug tools see stable values.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       undef;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_if.sv
// Instruction-field inputs, memory-ready handshake and control outputs of the main controller.
// master = the surrounding datapath/bench that drives Op/Funct/MemReady; slave = mainfsm.
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Undef;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Undef
    );

    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Undef
    );
endinterface

// File: rtl/mainfsm_outdec.sv
// Combinational state + MemReady -> control vector decode; zero latency, no backpressure of its own.
// Unreachable encodings decode to all-zero; the FSM moves them to UNKNOWN on the next edge.
module mainfsm_outdec
    import mainfsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] i_state,
    input  logic               i_mem_ready,
    output ctrl_t              o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            STATE_W'(FETCH): begin
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.result_src = RES_ALU;
                o_ctrl.ir_write   = i_mem_ready;
                o_ctrl.next_pc    = i_mem_ready;
            end
            STATE_W'(DECODE): begin
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.result_src = RES_ALU;
            end
            STATE_W'(MEMADR): begin
                o_ctrl.alu_src_a  = SRCA_REG;
                o_ctrl.alu_src_b  = SRCB_IMM;
            end
            STATE_W'(MEMRD): begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
            end
            STATE_W'(MEMWB): begin
                o_ctrl.result_src = RES_DATA;
                o_ctrl.reg_w      = 1'b1;
            end
            // Write strobe only on the cycle memory accepts it, so a stall never double-writes.
            STATE_W'(MEMWR): begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.mem_w      = i_mem_ready;
            end
            STATE_W'(EXECUTER): begin
                o_ctrl.alu_src_a  = SRCA_REG;
                o_ctrl.alu_src_b  = SRCB_REG;
                o_ctrl.alu_op     = 1'b1;
            end
            STATE_W'(EXECUTEI): begin
                o_ctrl.alu_src_a  = SRCA_REG;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = 1'b1;
            end
            STATE_W'(ALUWB): begin
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.reg_w      = 1'b1;
            end
            STATE_W'(BRANCH): begin
                o_ctrl.alu_src_a  = SRCA_REG;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.result_src = RES_ALU;
                o_ctrl.branch     = 1'b1;
            end
            STATE_W'(UNKNOWN): begin
                o_ctrl.undef      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle ARM main controller: fetch/decode/execute/writeback sequencing, MemReady stalls, sticky UNKNOWN trap.
// Moore outputs (MemReady-qualified in FETCH/MEMWR); forced to 0 while reset is low. Optional MAINFSM_STATE_OBS_EN adds StateObs.
module mainfsm
    import mainfsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mainfsm_if.slave           bus
`ifdef MAINFSM_STATE_OBS_EN
    ,
    output logic [STATE_W-1:0] StateObs
`endif
);

    logic [STATE_W-1:0] r_state;
    ctrl_t              w_ctrl;
    ctrl_t              w_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STATE_W'(FETCH);
        end else begin
            case (r_state)
                STATE_W'(FETCH):    if (bus.MemReady) r_state <= STATE_W'(DECODE);
                STATE_W'(DECODE): begin
                    case (bus.Op)
                        2'b01:   r_state <= STATE_W'(MEMADR);
                        2'b00:   r_state <= bus.Funct[5] ? STATE_W'(EXECUTEI) : STATE_W'(EXECUTER);
                        2'b10:   r_state <= STATE_W'(BRANCH);
                        default: r_state <= STATE_W'(UNKNOWN);
                    endcase
                end
                STATE_W'(MEMADR):   r_state <= bus.Funct[0] ? STATE_W'(MEMRD) : STATE_W'(MEMWR);
                STATE_W'(MEMRD):    if (bus.MemReady) r_state <= STATE_W'(MEMWB);
                STATE_W'(MEMWB):    r_state <= STATE_W'(FETCH);
                STATE_W'(MEMWR):    if (bus.MemReady) r_state <= STATE_W'(FETCH);
                STATE_W'(EXECUTER): r_state <= STATE_W'(ALUWB);
                STATE_W'(EXECUTEI): r_state <= STATE_W'(ALUWB);
                STATE_W'(ALUWB):    r_state <= STATE_W'(FETCH);
                STATE_W'(BRANCH):   r_state <= STATE_W'(FETCH);
                STATE_W'(UNKNOWN):  r_state <= STATE_W'(UNKNOWN);
                default:            r_state <= STATE_W'(UNKNOWN);
            endcase
        end
    end

    mainfsm_outdec #(.STATE_W(STATE_W)) u_outdec (
        .i_state     (r_state),
        .i_mem_ready (bus.MemReady),
        .o_ctrl      (w_ctrl)
    );

    // FETCH decodes to non-zero selects, so the reset level itself masks the outputs.
    assign w_out = reset ? w_ctrl : '0;

    assign bus.IRWrite   = w_out.ir_write;
    assign bus.AdrSrc    = w_out.adr_src;
    assign bus.ALUSrcA   = w_out.alu_src_a;
    assign bus.ALUSrcB   = w_out.alu_src_b;
    assign bus.ResultSrc = w_out.result_src;
    assign bus.ALUOp     = w_out.alu_op;
    assign bus.NextPC    = w_out.next_pc;
    assign bus.RegW      = w_out.reg_w;
    assign bus.MemW      = w_out.mem_w;
    assign bus.Branch    = w_out.branch;
    assign bus.Undef     = w_out.undef;

`ifdef MAINFSM_STATE_OBS_EN
    assign StateObs = r_state;
`endif

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: reset, LDR, FETCH stall, STR with MEMWR stall, ADD imm, B, UNKNOWN trap.
module tb_mainfsm;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mainfsm_if bus ();

`ifdef MAINFSM_STATE_OBS_EN
    logic [3:0] state_obs;
`endif

    mainfsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MAINFSM_STATE_OBS_EN
        ,
        .StateObs (state_obs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_UNK = 4'd10;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Undef}
    function automatic logic [13:0] vec(input logic ir, input logic adr, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] r, input logic op,
                                        input logic npc, input logic rw, input logic mw,
                                        input logic br, input logic ud);
        return {ir, adr, a, b, r, op, npc, rw, mw, br, ud};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp,
                bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.Undef};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [13:0] v);
        #1;
        chk({tag, "_state"}, 32'(dut.r_state), 32'(st));
        chk({tag, "_out"}, 32'(obs()), 32'(v));
`ifdef MAINFSM_STATE_OBS_EN
        chk({tag, "_obs"}, 32'(state_obs), 32'(st));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] V_FETCH, V_FETCH_STALL, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB;
    logic [13:0] V_MEMWR0, V_MEMWR1, V_EXEI, V_ALUWB, V_BRANCH, V_UNK;

    initial begin
        checks = 0;
        errors = 0;
        V_FETCH       = vec(1, 0, 2'b01, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0);
        V_FETCH_STALL = vec(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
        V_DECODE      = vec(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
        V_MEMADR      = vec(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        V_MEMRD       = vec(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        V_MEMWB       = vec(0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0);
        V_MEMWR0      = vec(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        V_MEMWR1      = vec(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
        V_EXEI        = vec(0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0);
        V_ALUWB       = vec(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
        V_BRANCH      = vec(0, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 1, 0);
        V_UNK         = vec(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);

        // Reset held with a live LDR on the inputs
        reset = 1'b0;
        bus.Op = 2'b01;
        bus.Funct = 6'b011001;
        bus.MemReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        step("rst", S_FETCH, 14'd0);

        // LDR: FETCH DECODE MEMADR MEMRD MEMWB FETCH
        reset = 1'b1;
        step("ldr_fetch", S_FETCH, V_FETCH);
        cyc(); step("ldr_decode", S_DECODE, V_DECODE);
        cyc(); step("ldr_memadr", S_MEMADR, V_MEMADR);
        cyc(); step("ldr_memrd", S_MEMRD, V_MEMRD);
        cyc(); step("ldr_memwb", S_MEMWB, V_MEMWB);
        cyc(); step("ldr_done", S_FETCH, V_FETCH);

        // One FETCH stall cycle, then STR with two MEMWR stall cycles
        bus.MemReady = 1'b0;
        bus.Funct = 6'b011000;
        step("fetch_stall", S_FETCH, V_FETCH_STALL);
        cyc(); step("fetch_stall_hold", S_FETCH, V_FETCH_STALL);
        bus.MemReady = 1'b1;
        step("str_fetch", S_FETCH, V_FETCH);
        cyc(); step("str_decode", S_DECODE, V_DECODE);
        cyc(); step("str_memadr", S_MEMADR, V_MEMADR);
        cyc(); bus.MemReady = 1'b0;
        step("str_memwr_w1", S_MEMWR, V_MEMWR0);
        cyc(); step("str_memwr_w2", S_MEMWR, V_MEMWR0);
        cyc(); bus.MemReady = 1'b1;
        step("str_memwr_go", S_MEMWR, V_MEMWR1);
        cyc(); step("str_done", S_FETCH, V_FETCH);

        // ADD immediate
        bus.Op = 2'b00;
        bus.Funct = 6'b101000;
        cyc(); step("add_decode", S_DECODE, V_DECODE);
        cyc(); step("add_exei", S_EXEI, V_EXEI);
        cyc(); step("add_aluwb", S_ALUWB, V_ALUWB);
        cyc(); step("add_done", S_FETCH, V_FETCH);

        // Branch
        bus.Op = 2'b10;
        cyc(); step("b_decode", S_DECODE, V_DECODE);
        cyc(); step("b_branch", S_BRANCH, V_BRANCH);
        cyc(); step("b_done", S_FETCH, V_FETCH);

        // Undefined opcode: sticky regardless of inputs
        bus.Op = 2'b11;
        cyc(); step("unk_decode", S_DECODE, V_DECODE);
        for (int i = 0; i < 10; i++) begin
            cyc();
            bus.Op = 2'(i);
            bus.Funct = 6'(i * 7);
            bus.MemReady = i[0];
            step("unk_hold", S_UNK, V_UNK);
        end

        // Asynchronous reset pulse away from a clock edge
        #1 reset = 1'b0;
        step("unk_rst", S_FETCH, 14'd0);
        reset = 1'b1;
        bus.MemReady = 1'b1;
        step("unk_release", S_FETCH, V_FETCH);

        // Reset mid-store: no MemW after release
        bus.Op = 2'b01;
        bus.Funct = 6'b011000;
        cyc(); cyc(); cyc();
        step("mid_memwr", S_MEMWR, V_MEMWR1);
        reset = 1'b0;
        step("mid_rst", S_FETCH, 14'd0);
        reset = 1'b1;
        step("mid_release", S_FETCH, V_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Main control state machine for the multicycle ARM processor.
- Sequences the shared datapath (memory, ALU, register file) through fetch/decode/execute/writeback and produces the unconditioned write enables (RegW, MemW, Branch, NextPC) that condlogic later gates with CondEx.
- Adds a memory-ready wait handshake on every memory access state.
- Traps unsupported opcodes in a sticky UNKNOWN state.

Parameters:
- STATE_W, 4, width of the state register; must be >= 4 (11 states).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]; bit5 = I (immediate), bit0 = L (load) / S
- MemReady  input  1  memory access completes this cycle
- IRWrite  output  1  instruction register load enable
- AdrSrc  output  1  0 = PC, 1 = ALUResult as memory address
- ALUSrcA  output  2  ALU A operand select
- ALUSrcB  output  2  ALU B operand select
- ResultSrc  output  2  result mux select
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add
- NextPC  output  1  PC write enable (unconditional)
- RegW  output  1  register write request (to condlogic)
- MemW  output  1  memory write request (to condlogic)
- Branch  output  1  branch request (to condlogic PCS path)
- Undef  output  1  high while in UNKNOWN

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- Reset (reset=0, asynchronous) forces FETCH. While reset is held, all outputs are 0.
- Outputs are Moore: decoded from the state only, except the MemReady qualifications listed below. Any field not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - IRWrite=NextPC=MemReady.
  - Next state: DECODE if MemReady, else stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5] -> EXECUTEI
  - Op=00 & !Funct[5] -> EXECUTER
  - Op=10 -> BRANCH
  - Op=11 -> UNKNOWN
- MEMADR: ALUSrcA=00, ALUSrcB=01. Next state: Funct[0] ? MEMRD : MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB if MemReady, else stay.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=MemReady (single-cycle write strobe). Next state: FETCH if MemReady, else stay.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next state: ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state: FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1. Next state: FETCH.
- UNKNOWN: Undef=1, all other outputs 0. Sticky until reset.
- Any unreachable encoding -> UNKNOWN on the next edge.
- Latencies with MemReady tied high:
  - LDR: 5 cycles
  - STR: 4 cycles
  - data-processing: 4 cycles
  - B: 3 cycles
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset asserted mid-instruction: immediate return to FETCH; no partial write is emitted after reset deasserts.

Optional Feature:
- Macro: MAINFSM_STATE_OBS_EN.
- Defined: adds output port StateObs [STATE_W-1:0] carrying the current state encoding (package values), reset value FETCH.
- Undefined: no port. Behaviour is otherwise identical.

Decomposition:
- Package mainfsm_pkg holds:
  - statetype enum with fixed encodings: FETCH=0 … UNKNOWN=10
  - localparams for mux selects: SRCA_REG=00, SRCA_PC=01, SRCB_REG=00, SRCB_IMM=01, SRCB_FOUR=10, RES_ALUOUT=00, RES_DATA=01, RES_ALU=10
- One sub-module, mainfsm_outdec: purely combinational state+MemReady -> control vector. The next-state logic stays in mainfsm.

Test Plan:
- Reset: hold reset=0 with Op=01, MemReady=1 for 3 cycles -> state FETCH, all outputs 0; first cycle after release shows IRWrite=1, NextPC=1, ALUSrcB=10.
- LDR (Op=01, Funct=011001, MemReady=1) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegW=1 only in cycle 5 with ResultSrc=01.
- STR with MemReady low for 2 cycles in MEMWR -> stays in MEMWR 3 cycles; MemW=1 only in the third; then FETCH.
- ADD immediate (Op=00, Funct=101000) -> EXECUTEI with ALUSrcB=01, ALUOp=1, then ALUWB with RegW=1; 4 cycles total.
- B (Op=10) -> BRANCH with Branch=1, ALUSrcB=01; then FETCH; 3 cycles total.
- Op=11 -> UNKNOWN, Undef=1 held for 10 cycles regardless of inputs; reset=0 pulse returns to FETCH.
